// File: rtl/bus_trace_uart_sched.sv
// bus_trace_uart_sched: queues bus events and sends each as an 11-byte ASCII line to uart_tx.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              gates new capture events only
//   cap_valid/write/addr/data  one-cycle bus event strobe and its payload
//   tx_req, tx_data     byte request to uart_tx; tx_ready accepts it
//   busy                line in flight or events queued
//   fifo_level          queued event count
//   dropped_count       saturating count of events lost to a full queue
module bus_trace_uart_sched #(
    parameter int FIFO_AW = 3,
    parameter int DROP_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cap_valid,
    input  logic               cap_write,
    input  logic [15:0]        cap_addr,
    input  logic [7:0]         cap_data,
    output logic               tx_req,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [DROP_W-1:0]  dropped_count
);
    localparam int DEPTH = 2**FIFO_AW;
    typedef enum logic {S_IDLE, S_SEND} state_t;
    state_t              r_state;
    logic [24:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wptr, r_rptr;
    logic [FIFO_AW:0]    r_level;
    logic [24:0]         r_line;
    logic [3:0]          r_idx;
    logic                r_tx_req;
    logic [7:0]          r_tx_data;
    logic [DROP_W-1:0]   r_drop;
    logic                w_pop, w_push_req, w_full, w_push, w_drop;
    assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
    assign w_push_req = cap_valid && enable;
    assign w_full     = r_level == (FIFO_AW+1)'(DEPTH);
    // a pop in the same cycle frees a slot, so a full queue still accepts
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
    function automatic logic [7:0] line_byte(input logic [24:0] e, input logic [3:0] i);
        case (i)
            4'd0:    return e[24] ? 8'h57 : 8'h52;
            4'd1:    return 8'h20;
            4'd2:    return hex(e[23:20]);
            4'd3:    return hex(e[19:16]);
            4'd4:    return hex(e[15:12]);
            4'd5:    return hex(e[11:8]);
            4'd6:    return 8'h3D;
            4'd7:    return hex(e[7:4]);
            4'd8:    return hex(e[3:0]);
            4'd9:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= {cap_write, cap_addr, cap_data};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
            if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
        end
    end
    // tx_data is loaded one step ahead so it is valid in the first SEND cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_idx     <= '0;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pop) begin
                r_line    <= r_mem[r_rptr];
                r_idx     <= '0;
                r_tx_req  <= 1'b1;
                r_tx_data <= line_byte(r_mem[r_rptr], 4'd0);
                r_state   <= S_SEND;
            end
        end else if (tx_ready) begin
            if (r_idx == 4'd10) begin
                r_tx_req <= 1'b0;
                r_state  <= S_IDLE;
            end else begin
                r_idx     <= r_idx + 4'd1;
                r_tx_data <= line_byte(r_line, r_idx + 4'd1);
            end
        end
    end
    assign tx_req        = r_tx_req;
    assign tx_data       = r_tx_data;
    assign fifo_level    = r_level;
    assign dropped_count = r_drop;
    assign busy          = (r_state == S_SEND) || (r_level != '0);
endmodule

// File: doc/bus_trace_uart_sched.md
Name: bus_trace_uart_sched

Overview:
- Captures RC2014 bus transaction events (address, data, read/write) into a small FIFO.
- Sequences each event as a fixed 11-byte ASCII line into the existing uart_tx byte interface, using the tx_req/tx_ready handshake.
- Sits between the bus-capture logic, which is already synchronised into the clk domain, and u_uart_tx.
- Replaces the ad-hoc periodic text formatter as the single owner of the UART.

Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW entries.
- DROP_W, 8: width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset (from sync_reset)
- enable  input  1  when 0, new capture events are ignored; any line in flight still completes
- cap_valid  input  1  one-cycle event strobe, synchronous to clk
- cap_write  input  1  1 = write cycle, 0 = read cycle; qualified by cap_valid
- cap_addr  input  16  bus address; qualified by cap_valid
- cap_data  input  8  bus data; qualified by cap_valid
- tx_req  output  1  byte request to uart_tx
- tx_data  output  8  byte to transmit; valid while tx_req=1
- tx_ready  input  1  uart_tx can accept; byte transfers in any cycle with tx_req && tx_ready
- busy  output  1  1 while a line is being sent or the FIFO is non-empty
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
- dropped_count  output  DROP_W  events lost to a full FIFO; saturates at all-ones

Behaviour:
- Reset (synchronous, active-high) clears the FIFO pointers and level, the FSM (to IDLE), byte index, tx_req, tx_data, and dropped_count. All outputs read 0 in the cycle after reset is sampled.
- Reset mid-line aborts the line. tx_req is 0 the next cycle, and queued events are discarded.
- Push condition: cap_valid && enable. The entry {cap_write, cap_addr, cap_data} (25 bits) is written at the clock edge; fifo_level increments.
- FIFO full (level = 2**FIFO_AW):
  - A push is dropped and dropped_count increments, saturating at 2**DROP_W-1.
  - Exception: a push in the same cycle as a pop is accepted, and the level is unchanged.
- A push and a pop in the same cycle on a non-full FIFO leave the level unchanged.
- Pointers wrap modulo 2**FIFO_AW.
- FSM states: IDLE, SEND.
  - IDLE with level>0: pop the head entry into the line register, set idx=0, go to SEND. tx_req stays 0 in this cycle.
  - SEND: tx_req=1 and tx_data=byte(idx). On tx_req && tx_ready:
    - if idx<10, then idx+1;
    - if idx=10, go to IDLE and drop tx_req the next cycle.
  - tx_req is never deasserted before acceptance, and tx_data is stable while tx_req=1 and the byte is not yet accepted.
- Line format, 11 bytes, index 0..10:
  - 0: 'W' (0x57) if write, else 'R' (0x52)
  - 1: ' ' (0x20)
  - 2..5: cap_addr nibbles [15:12], [11:8], [7:4], [3:0]
  - 6: '=' (0x3D)
  - 7..8: cap_data nibbles [7:4], [3:0]
  - 9: CR (0x0D)
  - 10: LF (0x0A)
- Hex digits are uppercase: nibble 0..9 maps to 0x30+n; A..F maps to 0x41+(n-10).
- Latency: with the FIFO empty and the FSM in IDLE, cap_valid in cycle N gives fifo_level=1 in N+1 (pop in N+1) and tx_req=1 with tx_data=0x57/0x52 in N+2.
- Back-to-back lines: after byte 10 is accepted, the FSM spends one cycle in IDLE (pop), then begins the next line. The gap with tx_req=0 is exactly one cycle.
- enable is sampled only for pushes. Dropping enable never affects tx_req or the FIFO contents.
- busy = (state==SEND) || (fifo_level!=0).

Test Plan:
- Reset, then a single event (write, addr 0x1234, data 0xAB) with tx_ready held 1 -> tx_req rises 2 cycles after cap_valid; bytes 57 20 31 32 33 34 3D 41 42 0D 0A; then tx_req=0 and busy=0.
- Read event addr 0xF00F, data 0x5C, with tx_ready toggling every 3 cycles -> byte sequence 52 20 46 30 30 46 3D 35 43 0D 0A; tx_data stable while stalled; no byte duplicated or skipped.
- Fill: 10 events on consecutive cycles while the first line is in flight, FIFO_AW=3 -> 1 popped, 8 queued, 1 dropped (dropped_count=1, fifo_level=8); all 9 lines emitted in order, with a one-cycle tx_req gap between lines.
- Push into a full FIFO in the same cycle as an IDLE pop -> push accepted, fifo_level stays 8, dropped_count unchanged.
- Assert reset at byte index 5 of a line with 3 events queued -> next cycle tx_req=0, fifo_level=0, dropped_count=0; no further bytes emitted.
- enable=0 while 4 cap_valid pulses arrive during a line in flight -> line completes normally; fifo_level stays 0 and dropped_count stays 0.
